// File: rtl/lsu_pkg.sv
// Shared encodings, state type and byte-enable helper for the load/store unit.
package lsu_pkg;

  // funct3 access-size encodings
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic {IDLE, WAIT} lsu_state_t;

  // Attributes of an accepted access, held for the read-latency cycle
  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic       we;
    logic [1:0] off;
  } lsu_cap_t;

  // Byte-enable mask from size[1:0] and byte offset; non-B/H/W sizes give 0
  function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Selects the addressed byte/half/word lane of a RAM read word and extends it.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select by offset, then sign/zero extension by size
  always_comb begin
    byte_v = 8'h00;
    half_v = 16'h0000;
    result = 32'h0;
    case (offset)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      LDST_B:  result = {{24{byte_v[7]}}, byte_v};
      LDST_BU: result = {24'h0, byte_v};
      LDST_H:  result = {{16{half_v[15]}}, half_v};
      LDST_HU: result = {16'h0, half_v};
      LDST_W:  result = rdata;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-side data-port initiator: issues one RAM access, stalls one cycle for
// the read latency, returns the extended load result; rejects bad accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_data_i,
  output logic              lsu_stall_req_o,
  output logic [31:0]       lsu_data_o,
  output logic              lsu_misaligned_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_wdata_o,
  input  logic [31:0]       data_rdata_i
);

  lsu_state_t  state, state_nx;
  lsu_cap_t    cap;
  logic        size_ok, aligned, legal, accept;
  logic [31:0] wdata_rep;
  logic [31:0] ld_data;

  lsu_load_extract u_extract (
    .rdata  (data_rdata_i),
    .size   ({cap.uns, cap.size}),
    .offset (cap.off),
    .result (ld_data)
  );

  // Legality: known size, no unsigned stores, natural alignment
  always_comb begin
    size_ok = (lsu_size_i == LDST_B) || (lsu_size_i == LDST_H) || (lsu_size_i == LDST_W) ||
              (lsu_size_i == LDST_BU) || (lsu_size_i == LDST_HU);
    case (lsu_size_i[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~lsu_addr_i[0];
      2'b10:   aligned = (lsu_addr_i[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    legal  = size_ok && aligned && !(lsu_we_i && lsu_size_i[2]);
    accept = reset && (state == IDLE) && lsu_req_i && legal;
  end

  // Replicate store data across every lane it may land in
  always_comb begin
    case (lsu_size_i[1:0])
      2'b00:   wdata_rep = {4{lsu_data_i[7:0]}};
      2'b01:   wdata_rep = {2{lsu_data_i[15:0]}};
      default: wdata_rep = lsu_data_i;
    endcase
  end

  // State and captured access attributes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cap   <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        cap <= '{size: lsu_size_i[1:0], uns: lsu_size_i[2], we: lsu_we_i, off: lsu_addr_i[1:0]};
    end
  end

  // Next state and all outputs; everything reads 0 while in reset
  always_comb begin
    state_nx         = state;
    lsu_stall_req_o  = 1'b0;
    lsu_data_o       = 32'h0;
    lsu_misaligned_o = 1'b0;
    data_req_o       = 1'b0;
    data_we_o        = 1'b0;
    data_be_o        = 4'b0000;
    data_addr_o      = '0;
    data_wdata_o     = 32'h0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_req_o      = 1'b1;
            data_we_o       = lsu_we_i;
            data_be_o       = lsu_be(lsu_size_i[1:0], lsu_addr_i[1:0]);
            data_addr_o     = lsu_addr_i;
            data_wdata_o    = wdata_rep;
            lsu_stall_req_o = 1'b1;
            state_nx        = WAIT;
          end else if (lsu_req_i) begin
            lsu_misaligned_o = 1'b1;
          end
        end
        WAIT: begin
          // Request still held by the core is the same instruction
          lsu_data_o = cap.we ? 32'h0 : ld_data;
          state_nx   = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small RAM model on the data port.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              lsu_req_i, lsu_we_i;
  logic [2:0]        lsu_size_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [31:0]       lsu_data_i;
  logic              lsu_stall_req_o, lsu_misaligned_o;
  logic [31:0]       lsu_data_o;
  logic              data_req_o, data_we_o;
  logic [3:0]        data_be_o;
  logic [ADDR_W-1:0] data_addr_o;
  logic [31:0]       data_wdata_o, data_rdata_i;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:15];

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_data_i       (lsu_data_i),
    .lsu_stall_req_o  (lsu_stall_req_o),
    .lsu_data_o       (lsu_data_o),
    .lsu_misaligned_o (lsu_misaligned_o),
    .data_req_o       (data_req_o),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_addr_o      (data_addr_o),
    .data_wdata_o     (data_wdata_o),
    .data_rdata_i     (data_rdata_i)
  );

  always #5 clk = ~clk;

  // RAM: byte-masked write at the request edge, registered read, sync reset
  always @(posedge clk) begin
    if (!reset) data_rdata_i <= 32'h0;
    else if (data_req_o) begin
      if (data_we_o) begin
        for (int b = 0; b < 4; b++)
          if (data_be_o[b]) mem[data_addr_o[5:2]][8*b +: 8] <= data_wdata_o[8*b +: 8];
      end else
        data_rdata_i <= mem[data_addr_o[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present a request, let combinational outputs settle
  task automatic drive(input logic req, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] data);
    lsu_req_i  = req;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = data;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full legal load: check issue cycle, then result cycle
  task automatic load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] exp);
    drive(1'b1, 1'b0, size, addr, 32'h0);
    chk({tag, " req"}, 32'(data_req_o), 32'd1);
    chk({tag, " stall"}, 32'(lsu_stall_req_o), 32'd1);
    chk({tag, " be"}, 32'(data_be_o), 32'(be));
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk({tag, " wait stall"}, 32'(lsu_stall_req_o), 32'd0);
    chk({tag, " data"}, lsu_data_o, exp);
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEAD_BEEF;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'h80F1_2345;
    reset = 1'b0;
    drive(1'b1, 1'b0, LDST_W, 32'h8, 32'h0);
    chk("rst req", 32'(data_req_o), 32'd0);
    chk("rst stall", 32'(lsu_stall_req_o), 32'd0);
    chk("rst be", 32'(data_be_o), 32'd0);
    step(); step();
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("idle req", 32'(data_req_o), 32'd0);
    chk("idle data", lsu_data_o, 32'h0);
    step();

    load("LB b", LDST_B, 32'hB, 4'b1000, 32'hFFFF_FF80);
    load("LHU a", LDST_HU, 32'hA, 4'b1100, 32'h0000_80F1);
    load("LH a", LDST_H, 32'hA, 4'b1100, 32'hFFFF_80F1);
    load("LW 8", LDST_W, 32'h8, 4'b1111, 32'h80F1_2345);
    load("LBU 9", LDST_BU, 32'h9, 4'b0010, 32'h0000_0023);

    // SB 0xAB at 0x5, upper store-data bits must not leak
    drive(1'b1, 1'b1, LDST_B, 32'h5, 32'h1234_56AB);
    chk("SB be", 32'(data_be_o), 32'b0010);
    chk("SB wdata", data_wdata_o, 32'hABAB_ABAB);
    chk("SB we", 32'(data_we_o), 32'd1);
    chk("SB addr", data_addr_o, 32'h5);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("SB wait data", lsu_data_o, 32'h0);
    step();
    load("LW 4 after SB", LDST_W, 32'h4, 4'b1111, 32'h1122_AB44);

    // Illegal and misaligned: flagged, no request, no stall, stays IDLE
    drive(1'b1, 1'b1, LDST_H, 32'h3, 32'hFFFF_FFFF);
    chk("SH3 mis", 32'(lsu_misaligned_o), 32'd1);
    chk("SH3 req", 32'(data_req_o), 32'd0);
    chk("SH3 stall", 32'(lsu_stall_req_o), 32'd0);
    step();
    drive(1'b1, 1'b0, LDST_W, 32'h6, 32'h0);
    chk("LW6 mis", 32'(lsu_misaligned_o), 32'd1);
    chk("LW6 req", 32'(data_req_o), 32'd0);
    step();
    drive(1'b1, 1'b1, LDST_BU, 32'h4, 32'hFFFF_FFFF);
    chk("SBU mis", 32'(lsu_misaligned_o), 32'd1);
    chk("SBU req", 32'(data_req_o), 32'd0);
    step();
    drive(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
    chk("sz011 mis", 32'(lsu_misaligned_o), 32'd1);
    step();
    drive(1'b0, 1'b0, LDST_H, 32'h3, 32'h0);
    chk("noreq mis", 32'(lsu_misaligned_o), 32'd0);
    step();
    load("LW 4 unchanged", LDST_W, 32'h4, 4'b1111, 32'h1122_AB44);

    // SH at 0x2 lands in the upper half
    drive(1'b1, 1'b1, LDST_H, 32'h2, 32'h0000_BEEF);
    chk("SH2 be", 32'(data_be_o), 32'b1100);
    chk("SH2 wdata", data_wdata_o, 32'hBEEF_BEEF);
    step(); step();
    load("LW 0 after SH", LDST_W, 32'h0, 4'b1111, 32'hBEEF_BEEF);

    // Back-to-back LW 0x0 then SW 0x4, request held high throughout
    drive(1'b1, 1'b0, LDST_W, 32'h0, 32'h0);
    chk("b2b c1 req", 32'(data_req_o), 32'd1);
    chk("b2b c1 stall", 32'(lsu_stall_req_o), 32'd1);
    step();
    drive(1'b1, 1'b0, LDST_W, 32'h0, 32'h0);
    chk("b2b c2 req", 32'(data_req_o), 32'd0);
    chk("b2b c2 stall", 32'(lsu_stall_req_o), 32'd0);
    chk("b2b c2 mis", 32'(lsu_misaligned_o), 32'd0);
    chk("b2b c2 data", lsu_data_o, 32'hBEEF_BEEF);
    step();
    drive(1'b1, 1'b1, LDST_W, 32'h4, 32'hCAFE_F00D);
    chk("b2b c3 req", 32'(data_req_o), 32'd1);
    chk("b2b c3 stall", 32'(lsu_stall_req_o), 32'd1);
    chk("b2b c3 wdata", data_wdata_o, 32'hCAFE_F00D);
    step();
    drive(1'b1, 1'b1, LDST_W, 32'h4, 32'hCAFE_F00D);
    chk("b2b c4 req", 32'(data_req_o), 32'd0);
    chk("b2b c4 stall", 32'(lsu_stall_req_o), 32'd0);
    chk("b2b c4 data", lsu_data_o, 32'h0);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();

    // Reset while in WAIT
    drive(1'b1, 1'b0, LDST_W, 32'h8, 32'h0);
    step();
    reset = 1'b0;
    drive(1'b1, 1'b0, LDST_W, 32'h8, 32'h0);
    chk("rstw data", lsu_data_o, 32'h0);
    chk("rstw req", 32'(data_req_o), 32'd0);
    chk("rstw stall", 32'(lsu_stall_req_o), 32'd0);
    step();
    reset = 1'b1;
    load("LW after rst", LDST_W, 32'h8, 4'b1111, 32'h80F1_2345);
    load("LW 4 final", LDST_W, 32'h4, 4'b1111, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
